// File: rtl/fib_stack.sv
// Registered LIFO return stack for the recursive Fibonacci datapath; frames are {tag, n}.
// Define FIB_STACK_STICKY_ERR_EN to make overflow/underflow sticky until rst (default: one-cycle pulses).
module fib_stack #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 3,
    parameter int TAG_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            push_n,
    input  logic [TAG_W-1:0]             push_tag,
    output logic [DATA_W-1:0]            top_n,
    output logic [TAG_W-1:0]             top_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = TAG_W + DATA_W;
    localparam logic [CW-1:0] SP_ZERO = CW'(0);
    localparam logic [CW-1:0] SP_ONE  = CW'(1);
    localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);

    logic [FW-1:0] mem_r [DEPTH];
    logic [CW-1:0] sp_r;
    logic [CW-1:0] sp_nxt_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] top_idx_s;
    logic [FW-1:0] top_frame_s;
    logic          empty_s;
    logic          full_s;
    logic          ovf_ev_s;
    logic          unf_ev_s;
    logic          overflow_r;
    logic          underflow_r;

    assign empty_s   = (sp_r == SP_ZERO);
    assign full_s    = (sp_r == SP_FULL);
    assign top_idx_s = AW'(sp_r - SP_ONE);

    // Resolve push/pop requests into the next pointer, a write strobe and error events.
    always_comb begin
        sp_nxt_s = sp_r;
        wr_en_s  = 1'b0;
        wr_idx_s = AW'(sp_r);
        ovf_ev_s = 1'b0;
        unf_ev_s = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full_s) begin
                    ovf_ev_s = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    sp_nxt_s = sp_r + SP_ONE;
                end
            end
            2'b01: begin
                if (empty_s) begin
                    unf_ev_s = 1'b1;
                end else begin
                    sp_nxt_s = sp_r - SP_ONE;
                end
            end
            2'b11: begin
                // Tail call replaces the top frame; on an empty stack only the push survives.
                if (empty_s) begin
                    wr_en_s  = 1'b1;
                    sp_nxt_s = SP_ONE;
                    unf_ev_s = 1'b1;
                end else begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = top_idx_s;
                end
            end
            default: begin
                sp_nxt_s = sp_r;
            end
        endcase
    end

    // Frame storage has no reset; only slots below sp are ever observed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= {push_tag, push_n};
        end
    end

    // Stack pointer and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r        <= SP_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            sp_r <= sp_nxt_s;
`ifdef FIB_STACK_STICKY_ERR_EN
            overflow_r  <= overflow_r  | ovf_ev_s;
            underflow_r <= underflow_r | unf_ev_s;
`else
            overflow_r  <= ovf_ev_s;
            underflow_r <= unf_ev_s;
`endif
        end
    end

    // Top-of-stack read, forced to zero while the stack is empty.
    always_comb begin
        top_frame_s = mem_r[top_idx_s];
        if (empty_s) begin
            top_n   = {DATA_W{1'b0}};
            top_tag = {TAG_W{1'b0}};
        end else begin
            top_n   = top_frame_s[DATA_W-1:0];
            top_tag = top_frame_s[FW-1:DATA_W];
        end
    end

    assign count     = sp_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
